riscv_wb_ctrl: RTL

//  Pipeline-side partner of riscv_regfile: tracks in-flight destinations (E, M, W stages),

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/riscv_fwd_mux.sv | 37 +++
 rtl/riscv_wb_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the writeback/bypass controller.
//   stage_t    - per-stage pipeline record (valid, write enable, load flag,
//                destination, sources, result data)
//   fwd_sel_e  - operand source select (regfile, M bypass, W bypass)
//   writesReg  - true when a stage will architecturally write a given register
package riscv_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned RegW  = 5;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic            is_load;
        logic [RegW-1:0] rd;
        logic [RegW-1:0] rs1;
        logic [RegW-1:0] rs2;
        logic [DataW-1:0] data;
    } stage_t;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_M,
        FWD_W
    } fwd_sel_e;

    // x0 is hardwired, so a write to it is never a real producer.
    function automatic logic writesReg(input stage_t s, input logic [RegW-1:0] r);
        return s.valid & s.we & (s.rd == r) & (r != '0);
    endfunction

endpackage

// File: rtl/riscv_fwd_mux.sv
// riscv_fwd_mux: resolves one E-stage operand.
//   rs      in   source register of the E-stage instruction
//   mStg    in   M-stage record
//   wStg    in   W-stage record
//   rfData  in   regfile read data for rs
//   sel     out  chosen source
//   operand out  resolved operand value
// M wins over W (younger producer). A load in M is never a bypass source:
// its data does not exist yet, and the stall logic keeps that case away.
module riscv_fwd_mux
    import riscv_pkg::*;
(
    input  logic [RegW-1:0]  rs,
    input  stage_t           mStg,
    input  stage_t           wStg,
    input  logic [DataW-1:0] rfData,
    output fwd_sel_e         sel,
    output logic [DataW-1:0] operand
);

    always_comb begin
        sel     = FWD_RF;
        operand = rfData;
        if (writesReg(mStg, rs) && !mStg.is_load) begin
            sel     = FWD_M;
            operand = mStg.data;
        end else if (writesReg(wStg, rs)) begin
            sel     = FWD_W;
            operand = wStg.data;
        end
    end

    // Source fields of the producing stages are irrelevant to bypassing.
    logic unusedFields;
    assign unusedFields = ^{mStg.rs1, mStg.rs2, wStg.is_load, wStg.rs1, wStg.rs2};

endmodule

// File: rtl/riscv_wb_ctrl.sv
// riscv_wb_ctrl: pipeline-side partner of riscv_regfile.
//   Tracks in-flight destinations through E/M/W, drives the regfile write
//   port and resolves E-stage operands with M/W bypass; stalls decode one
//   cycle on a load-use hazard.
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   dec_valid_i/rd/we/is_load/rs1/rs2   D-stage instruction
//   flush_i                 kill the D-stage instruction this cycle
//   ex_result_i             ALU result of the E-stage instruction
//   mem_rdata_i             load data of the M-stage instruction
//   rf_data_a_i/b_i         regfile read data (addresses driven from D)
//   op_a_o/op_b_o           resolved E-stage operands
//   stall_o                 hold D for one cycle
//   rf_addr_d_o             regfile AddrD at issue (0 for bubbles/stalls)
//   rf_data_d_o, rf_wen_o   regfile W-stage data and write enable
module riscv_wb_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    dec_valid_i,
    input  logic [$clog2(NREG)-1:0] dec_rd_i,
    input  logic                    dec_we_i,
    input  logic                    dec_is_load_i,
    input  logic [$clog2(NREG)-1:0] dec_rs1_i,
    input  logic [$clog2(NREG)-1:0] dec_rs2_i,
    input  logic                    flush_i,
    input  logic [XLEN-1:0]         ex_result_i,
    input  logic [XLEN-1:0]         mem_rdata_i,
    input  logic [XLEN-1:0]         rf_data_a_i,
    input  logic [XLEN-1:0]         rf_data_b_i,
    output logic [XLEN-1:0]         op_a_o,
    output logic [XLEN-1:0]         op_b_o,
    output logic                    stall_o,
    output logic [$clog2(NREG)-1:0] rf_addr_d_o,
    output logic [XLEN-1:0]         rf_data_d_o,
    output logic                    rf_wen_o
);

    stage_t eStg, mStg, wStg;
    logic   loadUse;
    logic   issue;

    always_comb begin
        loadUse = eStg.valid & eStg.we & eStg.is_load & (eStg.rd != '0) &
                  ((eStg.rd == dec_rs1_i) | (eStg.rd == dec_rs2_i));
        // Flush dominates: the killed instruction has no hazard to wait for.
        stall_o = dec_valid_i & ~flush_i & loadUse;
        // Reset gating keeps AddrD quiet while the pipeline is held clear.
        issue   = dec_valid_i & ~flush_i & ~stall_o & ~rst_i;
        rf_addr_d_o = (issue & dec_we_i) ? dec_rd_i : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eStg <= '0;
            mStg <= '0;
            wStg <= '0;
        end else begin
            if (issue) begin
                eStg <= '{valid: 1'b1, we: dec_we_i, is_load: dec_is_load_i,
                          rd: dec_rd_i, rs1: dec_rs1_i, rs2: dec_rs2_i, data: '0};
            end else begin
                eStg <= '0;
            end
            mStg      <= eStg;
            mStg.data <= ex_result_i;
            wStg      <= mStg;
            wStg.data <= mStg.is_load ? mem_rdata_i : mStg.data;
        end
    end

    assign rf_data_d_o = wStg.data;
    assign rf_wen_o    = wStg.valid & wStg.we & (wStg.rd != '0);

    fwd_sel_e fwdSelA, fwdSelB;

    riscv_fwd_mux fwdA (
        .rs      (eStg.rs1),
        .mStg    (mStg),
        .wStg    (wStg),
        .rfData  (rf_data_a_i),
        .sel     (fwdSelA),
        .operand (op_a_o)
    );

    riscv_fwd_mux fwdB (
        .rs      (eStg.rs2),
        .mStg    (mStg),
        .wStg    (wStg),
        .rfData  (rf_data_b_i),
        .sel     (fwdSelB),
        .operand (op_b_o)
    );

    // Selects are kept as named nets for trace visibility only.
    logic unusedSel;
    assign unusedSel = ^{fwdSelA, fwdSelB};

    // A dependent in E while its load sits in M would consume stale data.
    logic loadInMHazard;
    assign loadInMHazard = eStg.valid & mStg.valid & mStg.we & mStg.is_load &
                           (mStg.rd != '0) &
                           ((mStg.rd == eStg.rs1) | (mStg.rd == eStg.rs2));

    assert property (@(posedge clk_i) disable iff (rst_i) !loadInMHazard);

endmodule
